// File: rtl/e203_ddr_app_resp_if.sv
// MIG-style DDR3 user ("app_*") interface bundle.
// The master modport is the initiator (LSU/dcache side); the slave modport is the memory end.
interface e203_ddr_app_resp_if;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output init_calib_complete
    );
endinterface

// File: rtl/e203_ddr_app_resp.sv
// DDR3 app-interface responder: stands in for the memory controller.
// Holds 128-bit words in a local RAM, returns reads in order after RD_LAT cycles,
// and injects a post-reset calibration delay plus periodic refresh stalls on app_rdy.
module e203_ddr_app_resp #(
    parameter int MEM_AW      = 8,
    parameter int RD_LAT      = 4,
    parameter int INIT_CYCLES = 64,
    parameter int REF_PERIOD  = 512,
    parameter int REF_CYCLES  = 8,
    parameter int WDF_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    e203_ddr_app_resp_if.slave bus
);
    localparam int WORDS = 1 << MEM_AW;
    localparam int FP_W  = $clog2(WDF_DEPTH);
    localparam int CAL_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int RP_W  = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int RC_W  = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    localparam logic [CAL_W-1:0] CAL_LOAD = CAL_W'(INIT_CYCLES - 1);
    localparam logic [RP_W-1:0]  REF_LOAD = RP_W'(REF_PERIOD - 1);
    localparam logic [RC_W-1:0]  LEN_LOAD = RC_W'(REF_CYCLES - 1);
    localparam logic [FP_W:0]    WDF_FULL = (FP_W + 1)'(WDF_DEPTH);

    // Storage arrays carry no reset: RAM contents must survive rst_n.
    logic [127:0] ram      [WORDS];
    logic [127:0] wdf_data [WDF_DEPTH];
    logic [15:0]  wdf_mask [WDF_DEPTH];

    logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
    logic              calib_q, calib_d;
    logic [RP_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [RC_W-1:0]   ref_len_q, ref_len_d;
    logic              ref_act_q, ref_act_d;
    logic              wpend_q, wpend_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [FP_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FP_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FP_W:0]     wdf_cnt_q, wdf_cnt_d;
    logic              wdf_rdy_q, wdf_rdy_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [127:0]      rd_dat_q [RD_LAT];
    logic [127:0]      rd_dat_d [RD_LAT];

    logic [MEM_AW-1:0] word_idx;
    logic              app_rdy;
    logic              cmd_acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              wdf_push;
    logic              wdf_pop;

    // Byte offset and bits above the RAM depth are dropped, so large addresses alias.
    assign word_idx = bus.app_addr[MEM_AW+2:3];

    // Ready depends only on registered state, never on app_en.
    assign app_rdy = calib_q & ~wpend_q & ~ref_act_q;

    // Next-state logic for calibration, refresh, command accept, write FIFO and read pipeline.
    always_comb begin
        cal_cnt_d = cal_cnt_q;
        calib_d   = calib_q;
        ref_cnt_d = ref_cnt_q;
        ref_len_d = ref_len_q;
        ref_act_d = ref_act_q;
        wpend_d   = wpend_q;
        waddr_d   = waddr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wdf_cnt_d = wdf_cnt_q;

        if (!calib_q) begin
            if (cal_cnt_q == '0) calib_d = 1'b1;
            else                 cal_cnt_d = cal_cnt_q - 1'b1;
        end

        // Stall length countdown runs first so a new stall start can override it.
        if (ref_act_q) begin
            if (ref_len_q == '0) ref_act_d = 1'b0;
            else                 ref_len_d = ref_len_q - 1'b1;
        end
        if (calib_q) begin
            if (ref_cnt_q == '0) begin
                ref_cnt_d = REF_LOAD;
                ref_len_d = LEN_LOAD;
                ref_act_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q - 1'b1;
            end
        end

        cmd_acc  = bus.app_en & app_rdy;
        rd_acc   = cmd_acc & (bus.app_cmd == 3'b001);
        wr_acc   = cmd_acc & (bus.app_cmd == 3'b000);
        wdf_push = bus.app_wdf_wren & wdf_rdy_q;
        wdf_pop  = wpend_q & (wdf_cnt_q != '0);

        // wr_acc and wdf_pop are exclusive: accept needs ~wpend, commit needs wpend.
        if (wr_acc) begin
            wpend_d = 1'b1;
            waddr_d = word_idx;
        end
        if (wdf_pop) wpend_d = 1'b0;

        if (wdf_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (wdf_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wdf_push, wdf_pop})
            2'b10:   wdf_cnt_d = wdf_cnt_q + 1'b1;
            2'b01:   wdf_cnt_d = wdf_cnt_q - 1'b1;
            default: wdf_cnt_d = wdf_cnt_q;
        endcase
        wdf_rdy_d = (wdf_cnt_d != WDF_FULL);

        // RAM is sampled in the accept cycle; the pipeline only delays it.
        rd_vld_d[0] = rd_acc;
        rd_dat_d[0] = ram[word_idx];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_dat_d[i] = rd_dat_q[i-1];
        end
    end

    // State registers; reset drops in-flight reads and any buffered write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_cnt_q <= CAL_LOAD;
            calib_q   <= 1'b0;
            ref_cnt_q <= REF_LOAD;
            ref_len_q <= '0;
            ref_act_q <= 1'b0;
            wpend_q   <= 1'b0;
            waddr_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wdf_cnt_q <= '0;
            wdf_rdy_q <= 1'b0;
            rd_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
        end else begin
            cal_cnt_q <= cal_cnt_d;
            calib_q   <= calib_d;
            ref_cnt_q <= ref_cnt_d;
            ref_len_q <= ref_len_d;
            ref_act_q <= ref_act_d;
            wpend_q   <= wpend_d;
            waddr_q   <= waddr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wdf_cnt_q <= wdf_cnt_d;
            wdf_rdy_q <= wdf_rdy_d;
            rd_vld_q  <= rd_vld_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    // FIFO slot write on push; byte-masked RAM commit from the FIFO head.
    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data[wr_ptr_q] <= bus.app_wdf_data;
            wdf_mask[wr_ptr_q] <= bus.app_wdf_mask;
        end
        if (wdf_pop) begin
            for (int b = 0; b < 16; b++) begin
                if (!wdf_mask[rd_ptr_q][b]) ram[waddr_q][8*b +: 8] <= wdf_data[rd_ptr_q][8*b +: 8];
            end
        end
    end

    assign bus.app_rdy             = app_rdy;
    assign bus.app_wdf_rdy         = wdf_rdy_q;
    assign bus.app_rd_data         = rd_dat_q[RD_LAT-1];
    assign bus.app_rd_data_valid   = rd_vld_q[RD_LAT-1];
    assign bus.app_rd_data_end     = rd_vld_q[RD_LAT-1];
    assign bus.init_calib_complete = calib_q;

    // wdf_end is single-beat only and carries no information here.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.app_wdf_end, bus.app_addr[27:MEM_AW+3], bus.app_addr[2:0]};
endmodule
